fifo_unpacker: RTL and testbench
================================

FIFO_UNPACKER -- requirements
Module: fifo_unpacker

Interface
REQ-001 SHALL have parameter SIZE, default 16, the word width in bits.
REQ-002 SHALL have parameter PAR_READ, default 4, the number of words delivered per FIFO read.
REQ-003 SHALL have local parameter CNT_W = max(1, clog2(PAR_READ)), the lane counter width.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rstn, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port clear, input, 1 bit: synchronous flush.
REQ-007 SHALL have port fifo_empty, input, 1 bit: the FIFO has no complete PAR_READ group available.
REQ-008 SHALL have port fifo_ren, output, 1 bit: pops one PAR_READ group from the FIFO.
REQ-009 SHALL have port fifo_dout, input, SIZE*PAR_READ bits: the FIFO read data, valid in the same cycle as fifo_ren (show-ahead).
REQ-010 SHALL have port out_data, output, SIZE bits: the serialized word.
REQ-011 SHALL have port out_valid, output, 1 bit: out_data holds a valid word.
REQ-012 SHALL have port out_ready, input, 1 bit: the downstream sink accepts the word.
REQ-013 SHALL have port busy, output, 1 bit: a group is loaded and not yet fully sent.

Function
REQ-014 SHALL implement FSM states IDLE and SEND.
REQ-015 SHALL drive fifo_ren combinationally as (IDLE & !fifo_empty & !clear) | (SEND & last-lane handshake & !fifo_empty & !clear).
REQ-016 SHALL capture fifo_dout into a PAR_READ-lane holding register on every edge with fifo_ren=1, and reset lane_cnt to 0 on that edge.
REQ-017 SHALL transition IDLE->SEND on fifo_ren=1 and stay in IDLE otherwise.
REQ-018 SHALL, in SEND, hold out_valid=1 and drive out_data = lane[lane_cnt], where lane k = bits [k*SIZE +: SIZE] and lane 0 is sent first.
REQ-019 SHALL, on out_valid & out_ready with lane_cnt < PAR_READ-1, increment lane_cnt by 1.
REQ-020 SHALL, on a handshake with lane_cnt = PAR_READ-1 (the last lane), reload the next group with no bubble if !fifo_empty; otherwise go to IDLE.
REQ-021 SHALL hold out_data and lane_cnt stable while out_valid=1 and out_ready=0.
REQ-022 SHALL keep out_valid=0 in IDLE, with out_data=0.
REQ-023 SHALL drive busy = (state == SEND).
REQ-024 SHALL, on clear=1, go to IDLE, set lane_cnt=0, drop the held group, and not assert fifo_ren in that cycle; clear takes priority over any handshake.
REQ-025 SHALL, when PAR_READ=1, treat every handshake as the last lane.
REQ-026 SHALL never assert fifo_ren while fifo_empty=1.

Reset
REQ-027 SHALL, on rstn=0, asynchronously set state=IDLE, lane_cnt=0 and the holding register to 0.
REQ-028 SHALL hold all outputs during reset at out_valid=0, out_data=0, busy=0 and fifo_ren=0.
REQ-029 SHALL, if reset is asserted mid-group, discard the unsent lanes and issue no extra FIFO pop after release.

Structure
REQ-030 SHALL import the state encoding (IDLE=0, SEND=1) and the CNT_W helper from the shared package fifo_pkg.
REQ-031 SHALL be a single module with no sub-modules; the lane select is an inline indexed part-select.

Verification
REQ-032 SHALL cover a single group: SIZE=16, PAR_READ=4, fifo_dout=0x0004_0003_0002_0001, out_ready=1 -> one fifo_ren pulse, then out_data 0x0001, 0x0002, 0x0003, 0x0004 on 4 consecutive cycles, then out_valid=0.
REQ-033 SHALL cover back-to-back groups: fifo_empty=0 for 2 groups, out_ready=1 -> 8 consecutive valid cycles, a second fifo_ren in the same cycle as the 4th handshake, and no gap.
REQ-034 SHALL cover backpressure: out_ready=0 for 3 cycles on lane 1 -> out_data stays 0x0002, lane_cnt stays 1, and fifo_ren stays 0.
REQ-035 SHALL cover clear mid-group: clear after 2 handshakes -> next cycle IDLE, out_valid=0, no fifo_ren in the clear cycle, and the next group restarts at lane 0.
REQ-036 SHALL cover async reset mid-group: rstn=0 between edges -> out_valid=0 and busy=0 immediately, with no extra fifo_ren after release while fifo_empty=1.
REQ-037 SHALL cover PAR_READ=1: 3 words queued -> 3 fifo_ren pulses and 3 single-cycle words.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared FSM encoding and counter-width helper for the FIFO unpacker
package fifo_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/fifo_unpacker.sv
// fifo_unpacker: serializes PAR_READ-word FIFO groups into a one-word valid/ready stream
module fifo_unpacker
    import fifo_pkg::*;
#(
    parameter int SIZE     = 16,
    parameter int PAR_READ = 4
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     clear,
    input  logic                     fifo_empty,
    output logic                     fifo_ren,
    input  logic [SIZE*PAR_READ-1:0] fifo_dout,
    output logic [SIZE-1:0]          out_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic                     busy
);

    localparam int               CNT_W = cnt_w(PAR_READ);
    localparam logic [CNT_W-1:0] LAST  = CNT_W'(PAR_READ - 1);

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         lane_cnt_q, lane_cnt_d;
    logic [SIZE*PAR_READ-1:0] hold_q, hold_d;
    logic                     hs;
    logic                     last_hs;

    // handshake decode, show-ahead pop request and lane output; rstn gating keeps the pop quiet during reset
    always_comb begin
        hs        = (state_q == SEND) && out_ready;
        last_hs   = hs && (lane_cnt_q == LAST);
        fifo_ren  = rstn && !clear && !fifo_empty && ((state_q == IDLE) || last_hs);
        out_valid = state_q == SEND;
        busy      = state_q == SEND;
        out_data  = out_valid ? hold_q[int'(lane_cnt_q)*SIZE +: SIZE] : '0;
    end

    // next state: clear wins, then a pop reloads lane 0, then the last lane returns to idle
    always_comb begin
        state_d    = state_q;
        lane_cnt_d = lane_cnt_q;
        hold_d     = hold_q;
        if (clear) begin
            state_d    = IDLE;
            lane_cnt_d = '0;
            hold_d     = '0;
        end else if (fifo_ren) begin
            state_d    = SEND;
            lane_cnt_d = '0;
            hold_d     = fifo_dout;
        end else if (last_hs) begin
            state_d    = IDLE;
            lane_cnt_d = '0;
        end else if (hs) begin
            lane_cnt_d = lane_cnt_q + CNT_W'(1);
        end
    end

    // state, lane counter and holding register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q    <= IDLE;
            lane_cnt_q <= '0;
            hold_q     <= '0;
        end else begin
            state_q    <= state_d;
            lane_cnt_q <= lane_cnt_d;
            hold_q     <= hold_d;
        end
    end

endmodule

// File: tb/tb_fifo_unpacker.sv
// tb_fifo_unpacker: randomized and directed checks of the unpacker against a word-queue model
module tb_fifo_unpacker;

    localparam int SIZE = 16;
    localparam int PAR  = 4;

    logic                clk = 1'b0;
    logic                rstn;
    logic                clear;
    logic                fifo_empty;
    logic                fifo_ren;
    logic [SIZE*PAR-1:0] fifo_dout;
    logic [SIZE-1:0]     out_data;
    logic                out_valid;
    logic                out_ready;
    logic                busy;

    logic                p_clear;
    logic                p_empty;
    logic                p_ren;
    logic [SIZE-1:0]     p_dout;
    logic [SIZE-1:0]     p_data;
    logic                p_valid;
    logic                p_ready;
    logic                p_busy;

    int checks = 0;
    int passed = 0;

    logic [SIZE*PAR-1:0] fq[$];
    logic [SIZE-1:0]     pend[$];
    logic [SIZE-1:0]     got[$];
    int                  ren_cnt;
    logic                s_ren;
    logic                s_valid;
    logic [SIZE-1:0]     s_data;

    always #5 clk = ~clk;

    fifo_unpacker #(.SIZE(SIZE), .PAR_READ(PAR)) dut (
        .clk(clk), .rstn(rstn), .clear(clear), .fifo_empty(fifo_empty), .fifo_ren(fifo_ren),
        .fifo_dout(fifo_dout), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
    );

    fifo_unpacker #(.SIZE(SIZE), .PAR_READ(1)) dut1 (
        .clk(clk), .rstn(rstn), .clear(p_clear), .fifo_empty(p_empty), .fifo_ren(p_ren),
        .fifo_dout(p_dout), .out_data(p_data), .out_valid(p_valid), .out_ready(p_ready), .busy(p_busy)
    );

    task automatic drive_fifo();
        fifo_empty = fq.size() == 0;
        fifo_dout  = '0;
        if (fq.size() != 0) fifo_dout = fq[0];
    endtask

    // one cycle: compare outputs with the word-queue model at negedge, then advance past the next posedge
    task automatic tick();
        logic                er;
        logic                ev;
        logic [SIZE-1:0]     ed;
        logic [SIZE*PAR-1:0] g;
        @(negedge clk);
        ev = rstn && pend.size() != 0;
        er = rstn && !clear && fq.size() != 0 && (pend.size() == 0 || (out_ready && pend.size() == 1));
        ed = '0;
        if (ev) ed = pend[0];
        s_ren   = fifo_ren;
        s_valid = out_valid;
        s_data  = out_data;
        if (fifo_ren) ren_cnt++;
        if (out_valid && out_ready && !clear) got.push_back(out_data);
        checks++;
        if (fifo_ren !== er) $display("FAIL ren: got %b want %b at %0t", fifo_ren, er, $time);
        else passed++;
        checks++;
        if (out_valid !== ev) $display("FAIL valid: got %b want %b at %0t", out_valid, ev, $time);
        else passed++;
        checks++;
        if (busy !== ev) $display("FAIL busy: got %b want %b at %0t", busy, ev, $time);
        else passed++;
        checks++;
        if (out_data !== ed) $display("FAIL data: got %h want %h at %0t", out_data, ed, $time);
        else passed++;
        if (!rstn || clear) pend.delete();
        else begin
            if (ev && out_ready) void'(pend.pop_front());
            if (er) begin
                g = fq[0];
                for (int k = 0; k < PAR; k++) pend.push_back(g[k*SIZE +: SIZE]);
            end
        end
        @(posedge clk);
        #1;
        if (er) void'(fq.pop_front());
        drive_fifo();
    endtask

    task automatic test_reset();
        rstn      = 1'b0;
        clear     = 1'b0;
        out_ready = 1'b1;
        fq.push_back({$urandom, $urandom});
        drive_fifo();
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_ren !== 1'b0 || out_data !== '0)
            $display("FAIL reset_outputs: got v%b b%b r%b d%h want all zero", out_valid, busy, fifo_ren, out_data);
        else passed++;
        checks++;
        if (p_valid !== 1'b0 || p_busy !== 1'b0 || p_ren !== 1'b0)
            $display("FAIL reset_par1: got v%b b%b r%b want zero", p_valid, p_busy, p_ren);
        else passed++;
        repeat (2) tick();
        rstn = 1'b1;
        repeat (7) tick();
    endtask

    task automatic test_single_group();
        got.delete();
        ren_cnt = 0;
        out_ready = 1'b1;
        fq.push_back(64'h0004_0003_0002_0001);
        drive_fifo();
        tick();
        checks++;
        if (s_ren !== 1'b1 || s_valid !== 1'b0) $display("FAIL single_pop: got r%b v%b want r1 v0", s_ren, s_valid);
        else passed++;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_data !== SIZE'(i + 1))
                $display("FAIL single_lane%0d: got v%b %h want v1 %h", i, s_valid, s_data, SIZE'(i + 1));
            else passed++;
        end
        tick();
        checks++;
        if (s_valid !== 1'b0) $display("FAIL single_end: got valid %b want 0", s_valid);
        else passed++;
        checks++;
        if (ren_cnt != 1) $display("FAIL single_rencount: got %0d want 1", ren_cnt);
        else passed++;
    endtask

    task automatic test_back_to_back();
        fq.push_back({$urandom, $urandom});
        fq.push_back({$urandom, $urandom});
        drive_fifo();
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_ren !== (i == 3))
                $display("FAIL b2b_cycle%0d: got v%b r%b want v1 r%b", i, s_valid, s_ren, i == 3);
            else passed++;
        end
        tick();
        checks++;
        if (s_valid !== 1'b0) $display("FAIL b2b_end: got valid %b want 0", s_valid);
        else passed++;
    endtask

    task automatic test_backpressure();
        fq.push_back(64'h0004_0003_0002_0001);
        fq.push_back({$urandom, $urandom});
        drive_fifo();
        tick();
        tick();
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (s_valid !== 1'b1 || s_data !== 16'h0002 || s_ren !== 1'b0)
                $display("FAIL bp_hold%0d: got v%b %h r%b want v1 0002 r0", i, s_valid, s_data, s_ren);
            else passed++;
        end
        out_ready = 1'b1;
        repeat (9) tick();
    endtask

    task automatic test_clear();
        fq.push_back(64'h000d_000c_000b_000a);
        fq.push_back(64'h0014_0013_0012_0011);
        drive_fifo();
        repeat (3) tick();
        clear = 1'b1;
        tick();
        checks++;
        if (s_ren !== 1'b0) $display("FAIL clear_noren: got %b want 0", s_ren);
        else passed++;
        clear = 1'b0;
        tick();
        checks++;
        if (s_valid !== 1'b0 || s_ren !== 1'b1) $display("FAIL clear_idle: got v%b r%b want v0 r1", s_valid, s_ren);
        else passed++;
        tick();
        checks++;
        if (s_data !== 16'h0011) $display("FAIL clear_restart: got %h want 0011", s_data);
        else passed++;
        repeat (4) tick();
    endtask

    task automatic test_async_reset();
        fq.push_back({$urandom, $urandom});
        drive_fifo();
        tick();
        tick();
        #2 rstn = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || busy !== 1'b0 || fifo_ren !== 1'b0)
            $display("FAIL async_reset: got v%b b%b r%b want zero", out_valid, busy, fifo_ren);
        else passed++;
        tick();
        rstn = 1'b1;
        ren_cnt = 0;
        repeat (3) tick();
        checks++;
        if (ren_cnt != 0 || s_valid !== 1'b0) $display("FAIL async_nopop: got pops %0d v%b want 0 v0", ren_cnt, s_valid);
        else passed++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            if (fq.size() < 3 && $urandom_range(0, 2) == 0) fq.push_back({$urandom, $urandom});
            out_ready = $urandom_range(0, 3) != 0;
            clear     = $urandom_range(0, 40) == 0;
            drive_fifo();
            tick();
        end
        clear     = 1'b0;
        out_ready = 1'b1;
        repeat (20) tick();
        checks++;
        if (pend.size() != 0 || fq.size() != 0 || out_valid !== 1'b0)
            $display("FAIL random_drain: got pend %0d fifo %0d v%b want empty", pend.size(), fq.size(), out_valid);
        else passed++;
    endtask

    task automatic test_par1();
        logic [SIZE-1:0] pq[$];
        logic [SIZE-1:0] pw[3];
        logic [SIZE-1:0] pgot[$];
        logic            rn;
        int              pops = 0;
        for (int k = 0; k < 3; k++) begin
            pw[k] = SIZE'($urandom);
            pq.push_back(pw[k]);
        end
        p_ready = 1'b1;
        p_empty = 1'b0;
        p_dout  = pq[0];
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            rn = p_ren;
            checks++;
            if (p_valid !== (i >= 1 && i <= 3)) $display("FAIL par1_valid%0d: got %b want %b", i, p_valid, i >= 1 && i <= 3);
            else passed++;
            if (p_ren) pops++;
            if (p_valid && p_ready) pgot.push_back(p_data);
            @(posedge clk);
            #1;
            if (rn && pq.size() != 0) void'(pq.pop_front());
            p_empty = pq.size() == 0;
            p_dout  = '0;
            if (pq.size() != 0) p_dout = pq[0];
        end
        checks++;
        if (pops != 3) $display("FAIL par1_pops: got %0d want 3", pops);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (pgot.size() <= k) $display("FAIL par1_word%0d: got none want %h", k, pw[k]);
            else if (pgot[k] !== pw[k]) $display("FAIL par1_word%0d: got %h want %h", k, pgot[k], pw[k]);
            else passed++;
        end
    endtask

    initial begin
        p_clear = 1'b0;
        p_empty = 1'b1;
        p_dout  = '0;
        p_ready = 1'b0;
        ren_cnt = 0;
        test_reset();
        test_single_group();
        test_back_to_back();
        test_backpressure();
        test_clear();
        test_async_reset();
        test_random();
        test_par1();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded 200000 time units");
        $fatal(1);
    end

endmodule
